// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Optional build macro SEG_SCAN_CONFIRM_EN is used by seg_scan_decoder.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] AN_THOU  = 4'b0111;
    localparam logic [3:0] AN_HUND  = 4'b1011;
    localparam logic [3:0] AN_TENS  = 4'b1101;
    localparam logic [3:0] AN_ONES  = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    function automatic logic [13:0] mul10_add(
        input logic [13:0] acc,
        input logic [3:0]  d
    );
        return (acc << 3) + (acc << 1) + {10'd0, d};
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// Combinational decode of an active-low segment pattern to a BCD digit.
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       invalid
);

    always_comb begin
        digit   = 4'd0;
        invalid = 1'b0;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Captures a scanned 4-digit display and converts it back to binary.
// Build macro SEG_SCAN_CONFIRM_EN: publish only frames seen twice in a row.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode_in,
    input  logic [6:0]  seg_in,
    output logic [13:0] value_out,
    output logic [15:0] bcd_out,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] CAP_AT = 8'(SETTLE_CYCLES - 2);

    logic [3:0]            anode_q;
    logic [6:0]            seg_q;
    logic [7:0]            dwell;
    logic [NUM_DIGITS-1:0] mask;
    logic [NUM_DIGITS-1:0] inv;
    logic [15:0]           digs;
    logic                  same;
    logic                  capture;
    logic [3:0]            digit;
    logic                  invalid;
    logic                  slot_hit;
    logic                  blank;
    logic [1:0]            slot;
    logic [NUM_DIGITS-1:0] new_mask;
    logic [NUM_DIGITS-1:0] frame_inv;
    logic [15:0]           frame_bcd;
    logic                  start;

    state_t      state;
    logic [13:0] acc;
    logic [15:0] snap;
    logic [1:0]  didx;
    logic [13:0] result;
    logic [3:0]  cur_digit;
`ifdef SEG_SCAN_CONFIRM_EN
    logic [15:0] cand;
    logic        cand_vld;
`endif

    seg7_to_bcd u_dec (
        .seg     (seg_in),
        .digit   (digit),
        .invalid (invalid)
    );

    assign same    = (anode_in == anode_q) && (seg_in == seg_q);
    assign capture = same && (dwell == CAP_AT);

    always_comb begin
        slot_hit = 1'b0;
        blank    = 1'b0;
        slot     = 2'd0;
        unique case (1'b1)
            (anode_in == AN_THOU):  begin slot_hit = 1'b1; slot = 2'd3; end
            (anode_in == AN_HUND):  begin slot_hit = 1'b1; slot = 2'd2; end
            (anode_in == AN_TENS):  begin slot_hit = 1'b1; slot = 2'd1; end
            (anode_in == AN_ONES):  begin slot_hit = 1'b1; slot = 2'd0; end
            (anode_in == AN_BLANK): blank = 1'b1;
            default: ;
        endcase
    end

    // Frame contents as they would be after this capture lands.
    always_comb begin
        frame_bcd = digs;
        frame_inv = inv;
        new_mask  = mask;
        if (slot_hit) begin
            frame_bcd[{slot, 2'b00} +: 4] = digit;
            frame_inv[slot]               = invalid;
            new_mask[slot]                = 1'b1;
        end
    end

    assign start = capture && slot_hit && (&new_mask) && !(|frame_inv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q <= 4'd0;
            seg_q   <= 7'd0;
            dwell   <= 8'd0;
            mask    <= '0;
            inv     <= '0;
            digs    <= 16'd0;
            err     <= 1'b0;
        end else begin
            anode_q <= anode_in;
            seg_q   <= seg_in;
            err     <= 1'b0;
            if (!same)
                dwell <= 8'd0;
            else if (dwell != 8'hFF)
                dwell <= dwell + 8'd1;
            if (capture) begin
                if (slot_hit) begin
                    digs <= frame_bcd;
                    inv  <= frame_inv;
                    if (&new_mask) begin
                        mask <= '0;
                        err  <= |frame_inv;
                    end else begin
                        mask <= new_mask;
                    end
                end else if (!blank) begin
                    mask <= '0;
                    err  <= 1'b1;
                end
            end
        end
    end

    assign cur_digit = snap[{didx, 2'b00} +: 4];
    assign result    = mul10_add(acc, cur_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 14'd0;
            snap      <= 16'd0;
            didx      <= 2'd0;
            value_out <= 14'd0;
            bcd_out   <= 16'd0;
            valid     <= 1'b0;
`ifdef SEG_SCAN_CONFIRM_EN
            cand      <= 16'd0;
            cand_vld  <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= frame_bcd;
                        acc   <= 14'd0;
                        didx  <= 2'd3;
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc  <= result;
                    didx <= didx - 2'd1;
                    if (didx == 2'd0) begin
                        state <= DONE;
`ifdef SEG_SCAN_CONFIRM_EN
                        cand     <= snap;
                        cand_vld <= 1'b1;
                        if (cand_vld && cand == snap) begin
                            value_out <= result;
                            bcd_out   <= snap;
                            valid     <= 1'b1;
                        end
`else
                        value_out <= result;
                        bcd_out   <= snap;
                        valid     <= 1'b1;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized bench for seg_scan_decoder against a frame-level model.
// Honours SEG_SCAN_CONFIRM_EN in the model when defined.
module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  anode_in = 4'hF;
    logic [6:0]  seg_in = 7'h7F;
    logic [13:0] value_out;
    logic [15:0] bcd_out;
    logic        valid;
    logic        err;

    seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .anode_in  (anode_in),
        .seg_in    (seg_in),
        .value_out (value_out),
        .bcd_out   (bcd_out),
        .valid     (valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                             7'b0000110, 7'b1001100, 7'b0100100,
                             7'b0100000, 7'b0001111, 7'b0000000,
                             7'b0000100};

    bit   m_mask [4];
    int   m_dig [4];
    bit   m_inv [4];
    bit   exp_v [int];
    int   exp_val [int];
    bit   exp_e [int];
    int   held_val = 0;
    int   cand = 0;
    bit   cand_v = 0;
    logic [3:0] last_a = 4'hF;
    logic [6:0] last_s = 7'h7F;

    function automatic int seg_digit(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (pat[i] == s) return i;
        return -1;
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 1000) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic clear_mask();
        for (int i = 0; i < 4; i++) m_mask[i] = 0;
    endtask

    task automatic model_capture(input logic [3:0] a, input logic [6:0] s,
                                 input int tc);
        int z, slot, d, v;
        z = 4 - $countones(a);
        if (z == 0) return;
        if (z >= 2) begin
            clear_mask();
            exp_e[tc] = 1;
            return;
        end
        slot = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) slot = i;
        d = seg_digit(s);
        m_dig[slot]  = d;
        m_inv[slot]  = (d < 0);
        m_mask[slot] = 1;
        if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
            clear_mask();
            if (m_inv[0] || m_inv[1] || m_inv[2] || m_inv[3]) begin
                exp_e[tc] = 1;
            end else begin
                v = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
`ifdef SEG_SCAN_CONFIRM_EN
                if (cand_v && cand == v) begin
                    exp_v[tc + 4]   = 1;
                    exp_val[tc + 4] = v;
                end
                cand   = v;
                cand_v = 1;
`else
                exp_v[tc + 4]   = 1;
                exp_val[tc + 4] = v;
`endif
            end
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s,
                         input int len);
        int e0;
        if (a == last_a && s == last_s) begin
            anode_in = 4'hF;
            seg_in   = 7'h7F;
            @(posedge clk); #1;
        end
        anode_in = a;
        seg_in   = s;
        last_a   = a;
        last_s   = s;
        e0 = cyc + 1;
        if (len >= S) model_capture(a, s, e0 + S - 1);
        repeat (len) begin @(posedge clk); #1; end
    endtask

    task automatic scan(input int v, input int len);
        int dg [4];
        logic [3:0] a;
        dg[3] = v / 1000;
        dg[2] = (v / 100) % 10;
        dg[1] = (v / 10) % 10;
        dg[0] = v % 10;
        for (int k = 3; k >= 0; k--) begin
            a = 4'hF;
            a[k] = 1'b0;
            dwell(a, pat[dg[k]], len);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_v.delete();
        exp_val.delete();
        exp_e.delete();
        held_val = 0;
        cand_v   = 0;
        clear_mask();
        @(posedge clk); #1;
        rst      = 1'b0;
        anode_in = 4'hF;
        seg_in   = 7'h7F;
        last_a   = 4'hF;
        last_s   = 7'h7F;
    endtask

    always @(negedge clk) begin
        if (exp_v.exists(cyc)) held_val = exp_val[cyc];
        check("valid", valid, exp_v.exists(cyc));
        check("err", err, exp_e.exists(cyc));
        check("value", value_out, held_val);
        check("bcd", bcd_out, to_bcd(held_val));
    end

    task automatic rand_dwell();
        logic [3:0] a;
        logic [6:0] s;
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) begin
            a = 4'hF;
            a[$urandom_range(0, 3)] = 1'b0;
        end else if (r == 7) begin
            a = 4'hF;
        end else begin
            a = 4'($urandom);
            while ($countones(a) > 2) a = 4'($urandom);
        end
        if ($urandom_range(0, 9) < 9)
            s = pat[$urandom_range(0, 9)];
        else
            s = 7'($urandom);
        dwell(a, s, $urandom_range(1, 2 * S + 2));
    endtask

    initial begin
        logic [3:0] a;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        dwell(4'hF, 7'h7F, 3);

        scan(255, 8);
        dwell(4'hF, 7'h7F, 10);
        scan(510, 8);
        dwell(4'hF, 7'h7F, 6);
        scan(0, 8);
        dwell(4'hF, 7'h7F, 6);

        dwell(4'b0111, pat[0], 8);
        dwell(4'b1011, pat[2], 8);
        dwell(4'b1101, 7'b1111111, 8);
        dwell(4'b1110, pat[5], 8);
        dwell(4'hF, 7'h7F, 6);

        dwell(4'b0111, pat[0], 8);
        dwell(4'b1011, pat[2], 8);
        dwell(4'b0011, pat[8], S);
        scan(255, 8);
        dwell(4'hF, 7'h7F, 6);

        scan(1234, S - 1);
        dwell(4'hF, 7'h7F, 6);

        dwell(4'b0111, pat[9], 8);
        dwell(4'b1011, pat[8], 8);
        dwell(4'b1101, pat[7], 8);
        dwell(4'b1110, pat[6], S);
        repeat (2) begin @(posedge clk); #1; end
        do_reset();
        dwell(4'hF, 7'h7F, 10);

        scan(255, 8);
        scan(256, 8);
        scan(256, 8);
        dwell(4'hF, 7'h7F, 10);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                scan($urandom_range(0, 9999), $urandom_range(S, 3 * S));
            end else begin
                for (int j = 0; j < 8; j++) rand_dwell();
            end
        end
        dwell(4'hF, 7'h7F, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
